// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS layout and transmitter state encoding for uart_tx_periph.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  count;
    logic        ovf;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers, head visible on rdata with zero latency.
// Pushes while full and pops while empty are ignored; the producer checks full to detect drops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO; frames take 10*DIV cycles plus one idle cycle.
// No bus backpressure: DATA writes to a full FIFO are dropped and flagged in sticky STATUS.OVF.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEFAULT_DIV = 16,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        hit,
  output logic        txd,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [1:0]    reg_off;
  logic          wr;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_rdata;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [15:0]   div_q;
  logic          ovf_q;
  status_t       status;
  logic          unused_bits;

  tx_state_t   state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_d;
  logic        last;

  assign hit         = (daddr[31:4] == BASE_ADDR[31:4]);
  assign reg_off     = daddr[3:2];
  assign wr          = hit && (dwe != 4'b0000) && !reset;
  assign push        = wr && (reg_off == REG_DATA) && dwe[0];
  assign unused_bits = ^{daddr[1:0], dwdata[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (dwdata[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 16'(DEFAULT_DIV);
      ovf_q <= 1'b0;
    end else begin
      if (push && full)
        ovf_q <= 1'b1;
      else if (wr && (reg_off == REG_STATUS) && dwe[0] && dwdata[ST_OVF])
        ovf_q <= 1'b0;
      if (wr && (reg_off == REG_DIV)) begin
        if (dwe[0]) div_q[7:0]  <= dwdata[7:0];
        if (dwe[1]) div_q[15:8] <= dwdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      div_lat_q <= 16'd1;
      txd       <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      div_lat_q <= div_lat_d;
      txd       <= txd_d;
    end
  end

  assign last = (cyc_q == div_lat_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          sh_d      = fifo_rdata;
          div_lat_d = (div_q == 16'd0) ? 16'd1 : div_q;
          cyc_d     = '0;
          bit_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (last) begin
          cyc_d   = '0;
          state_d = DATA;
        end else cyc_d = cyc_q + 16'd1;
      end
      DATA: begin
        if (last) begin
          cyc_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else bit_d = bit_q + 3'd1;
        end else cyc_d = cyc_q + 16'd1;
      end
      STOP: begin
        if (last) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else cyc_d = cyc_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // txd is computed from the next state so the line moves on the same edge as the FSM
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    status       = '0;
    status.count = 4'(count);
    status.ovf   = ovf_q;
    status.busy  = (state_q != IDLE);
    status.empty = empty;
    status.full  = full;
  end

  always_comb begin
    drdata = '0;
    if (hit) begin
      case (reg_off)
        REG_STATUS: drdata = status;
        REG_DIV:    drdata = {16'd0, div_q};
        default:    drdata = '0;
      endcase
    end
  end

  assign irq = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: a line monitor decodes each frame and checks it
// sample-by-sample against the expected byte and divisor queued when the DATA write was driven.
module tb_uart_tx_periph;
  import uart_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        hit;
  logic        txd;
  logic        irq;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t sb[$];
  int     n_tests    = 0;
  int     n_fail     = 0;
  int     frames_seen = 0;
  bit     abort_mon  = 1'b0;

  always #5 clk = ~clk;

  uart_tx_periph #(
    .BASE_ADDR   (BASE),
    .DEFAULT_DIV (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwe    (dwe),
    .drdata (drdata),
    .hit    (hit),
    .txd    (txd),
    .irq    (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    daddr  = a;
    dwdata = d;
    dwe    = be;
    @(negedge clk);
    dwe    = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    daddr = a;
    dwe   = 4'b0000;
    #1;
    d = drdata;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] s;
    bit          done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      rd(BASE + 32'h4, s);
      if (s[ST_BUSY] == 1'b0 && s[ST_EMPTY] == 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  // Line monitor: every sample of a frame must match start/data/stop for the queued divisor
  initial begin : monitor
    logic       prev;
    frame_t     f;
    int         bad;
    int         d;
    logic [7:0] rx;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0) begin
        frames_seen++;
        chk("sb_has_frame", (sb.size() > 0), 1);
        if (sb.size() > 0) f = sb.pop_front();
        else begin
          f.data = 8'h00;
          f.div  = 1;
        end
        bad = 0;
        rx  = 8'h00;
        d   = f.div;
        for (int k = 0; k < 10 * d; k++) begin
          logic expb;
          if (k > 0) @(negedge clk);
          if (abort_mon) break;
          if (k < d) expb = 1'b0;
          else if (k >= 9 * d) expb = 1'b1;
          else expb = f.data[k / d - 1];
          if (txd !== expb) bad++;
          if (k >= d && k < 9 * d && (k % d) == d / 2) rx[k / d - 1] = txd;
        end
        if (!abort_mon) begin
          chk("frame_data", rx, f.data);
          chk("frame_timing_bad_samples", bad, 0);
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] r;
    logic [7:0]  burst [6];
    int          busy_n;
    int          fs0;

    reset  = 1'b1;
    daddr  = BASE;
    dwdata = '0;
    dwe    = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_txd", txd, 1);
    chk("reset_irq", irq, 1);
    chk("reset_hit", hit, 1);
    rd(BASE + 32'h4, r); chk("reset_status", r, 32'h2);
    rd(BASE + 32'h8, r); chk("reset_div", r, 32'd16);
    rd(BASE + 32'h0, r); chk("data_reads_zero", r, 32'h0);

    // byte-lane DIV writes
    wr(BASE + 32'h8, 32'h0000_AB00, 4'b0010);
    rd(BASE + 32'h8, r); chk("div_lane1", r, 32'h0000_AB10);
    wr(BASE + 32'h8, 32'hFFFF_0004, 4'b1111);
    rd(BASE + 32'h8, r); chk("div_upper_zero", r, 32'h4);

    // 0x55 at DIV=4: BUSY for exactly 40 cycles
    sb.push_back('{8'h55, 4});
    wr(BASE, 32'h55, 4'b0001);
    busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      rd(BASE + 32'h4, r);
      if (r[ST_BUSY]) busy_n++;
      else break;
    end
    chk("busy_cycles", busy_n, 40);
    wait_idle("idle_after_55", 200);
    chk("irq_idle", irq, 1);

    // DATA write without lane 0 pushes nothing
    wr(BASE, 32'h0000_00AA, 4'b0010);
    rd(BASE + 32'h4, r); chk("data_no_lane0", r, 32'h2);

    // divisor latched at frame start
    sb.push_back('{8'h3C, 4});
    sb.push_back('{8'hC3, 8});
    wr(BASE, 32'h3C, 4'b0001);
    wr(BASE, 32'hC3, 4'b0001);
    repeat (10) @(negedge clk);
    wr(BASE + 32'h8, 32'h8, 4'b0011);
    wait_idle("idle_after_div_change", 500);
    chk("sb_empty_div_change", sb.size(), 0);

    // stored DIV of 0 behaves as 1
    wr(BASE + 32'h8, 32'h0, 4'b0011);
    rd(BASE + 32'h8, r); chk("div_zero_stored", r, 32'h0);
    sb.push_back('{8'h96, 1});
    wr(BASE, 32'h96, 4'b0001);
    wait_idle("idle_after_div0", 100);

    // six back-to-back writes into a depth-4 FIFO
    wr(BASE + 32'h8, 32'd16, 4'b0011);
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      daddr  = BASE;
      dwdata = {24'h0, burst[i]};
      dwe    = 4'b0001;
      if (i < 5) sb.push_back('{burst[i], 16});
    end
    @(negedge clk);
    dwe = 4'b0000;
    rd(BASE + 32'h4, r); chk("overflow_status", r, 32'h4D);
    wr(BASE + 32'h4, 32'h8, 4'b0010);
    rd(BASE + 32'h4, r); chk("ovf_kept_wrong_lane", r, 32'h4D);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    rd(BASE + 32'h4, r); chk("ovf_cleared", r, 32'h45);
    wait_idle("idle_after_burst", 2000);
    chk("sb_empty_burst", sb.size(), 0);

    // out-of-window and reserved accesses
    rd(BASE + 32'h10, r);
    chk("oow_hit", hit, 0);
    chk("oow_rdata", r, 32'h0);
    wr(BASE + 32'h18, 32'h1234, 4'b1111);
    wr(BASE + 32'h10, 32'h5A, 4'b0001);
    wr(BASE + 32'h14, 32'h8, 4'b0001);
    wr(BASE + 32'hC, 32'hFFFF, 4'b1111);
    rd(BASE + 32'hC, r); chk("reserved_reads_zero", r, 32'h0);
    rd(BASE + 32'h8, r); chk("oow_div_unchanged", r, 32'd16);
    rd(BASE + 32'h4, r); chk("oow_status_unchanged", r, 32'h2);

    // reset during data bit 3 aborts the frame and flushes the FIFO
    wr(BASE + 32'h8, 32'h4, 4'b0011);
    sb.push_back('{8'hA5, 4});
    wr(BASE, 32'hA5, 4'b0001);
    wr(BASE, 32'h3C, 4'b0001);
    repeat (16) @(negedge clk);
    abort_mon = 1'b1;
    reset     = 1'b1;
    daddr     = BASE;
    dwdata    = 32'h77;
    dwe       = 4'b0001;
    @(negedge clk);
    reset = 1'b0;
    dwe   = 4'b0000;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_irq", irq, 1);
    rd(BASE + 32'h4, r); chk("abort_status", r, 32'h2);
    fs0 = frames_seen;
    repeat (100) @(negedge clk);
    chk("no_frame_after_reset", frames_seen, fs0);
    chk("txd_idle_after_reset", txd, 1);
    abort_mon = 1'b0;
    chk("sb_empty_final", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
